// File: rtl/truth_table_scanner.sv
// truth_table_scanner
// Sequential exerciser for a combinational N_IN-input boolean function.
// Walks vec through every input combination and captures the response into
// table_out. It then streams the indices of the set entries (minterms) over a
// valid/ready interface and reports their count.
// Optional feature macro: TTS_MAXTERM_EN adds a mode_max input. When mode_max
// is high at start, the scan streams the zero entries (maxterms) instead.
module truth_table_scanner #(
    parameter int N_IN       = 4,
    parameter int SAMPLE_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [N_IN-1:0]      vec,
    input  logic                 f_in,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 minterm_valid,
    input  logic                 minterm_ready,
    output logic [N_IN-1:0]      minterm_idx,
    output logic                 minterm_last,
    output logic [N_IN:0]        minterm_count
`ifdef TTS_MAXTERM_EN
    ,
    input  logic                 mode_max
`endif
);

    localparam int              DEPTH      = 1 << N_IN;
    localparam logic [N_IN-1:0] MAX_IDX    = {N_IN{1'b1}};
    localparam logic [1:0]      DRAIN_LAST = (SAMPLE_LAT > 0) ? 2'(SAMPLE_LAT - 1) : 2'd0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_DRAIN = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [DEPTH-1:0]   table_q, table_d;
    logic [N_IN:0]      count_q, count_d;
    logic [N_IN-1:0]    ptr_q, ptr_d;
    logic [1:0]         drain_q, drain_d;
    logic               mode_s;

    // Tag pipeline output: which captured index f_in belongs to this cycle.
    logic               tag_v_s;
    logic [N_IN-1:0]    tag_idx_s;

    logic [DEPTH-1:0]   sel_vec_s;
    logic [DEPTH-1:0]   above_s;
    logic               sel_bit_s;
    logic               emit_s;
    logic               advance_s;

    // Number of set bits in the selected table view.
    function automatic logic [N_IN:0] popcount(input logic [DEPTH-1:0] v);
        logic [N_IN:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{N_IN{1'b0}}, v[i]};
        end
        return c;
    endfunction

`ifdef TTS_MAXTERM_EN
    logic mode_q, mode_d;
    assign mode_s = mode_q;
`else
    assign mode_s = 1'b0;
`endif

    // Maxterm mode streams zero entries, so work on an inverted table view.
    assign sel_vec_s = table_q ^ {DEPTH{mode_s}};
    assign sel_bit_s = sel_vec_s[ptr_q];
    assign above_s   = (sel_vec_s >> ptr_q) >> 1'b1;
    assign emit_s    = (state_q == S_EMIT);
    // A clear entry is skipped at once; a set entry waits for the consumer.
    assign advance_s = emit_s && (!sel_bit_s || minterm_ready);

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign vec           = vec_q;
    assign table_out     = table_q;
    assign minterm_valid = emit_s && sel_bit_s;
    assign minterm_idx   = ptr_q;
    assign minterm_last  = emit_s && sel_bit_s && (above_s == '0);
    assign minterm_count = count_q;

    generate
        if (SAMPLE_LAT == 0) begin : g_nolat
            assign tag_v_s   = (state_q == S_DRIVE);
            assign tag_idx_s = vec_q;
        end else begin : g_lat
            logic            v_q   [SAMPLE_LAT];
            logic [N_IN-1:0] idx_q [SAMPLE_LAT];

            // Delay each presented index by SAMPLE_LAT cycles to align with f_in.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SAMPLE_LAT; i++) begin
                        v_q[i]   <= 1'b0;
                        idx_q[i] <= '0;
                    end
                end else begin
                    v_q[0]   <= (state_q == S_DRIVE);
                    idx_q[0] <= vec_q;
                    for (int i = 1; i < SAMPLE_LAT; i++) begin
                        v_q[i]   <= v_q[i-1];
                        idx_q[i] <= idx_q[i-1];
                    end
                end
            end

            assign tag_v_s   = v_q[SAMPLE_LAT-1];
            assign tag_idx_s = idx_q[SAMPLE_LAT-1];
        end
    endgenerate

    // Next-state logic: scan sequencing, table capture and the emit pointer.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        table_d = table_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        drain_d = drain_q;
`ifdef TTS_MAXTERM_EN
        mode_d  = mode_q;
`endif
        if (tag_v_s) begin
            table_d[tag_idx_s] = f_in;
        end else begin
            table_d = table_q;
        end

        case (state_q)
            S_IDLE: begin
                vec_d = '0;
                ptr_d = '0;
                if (start) begin
                    table_d = '0;
                    count_d = '0;
`ifdef TTS_MAXTERM_EN
                    mode_d  = mode_max;
`endif
                    state_d = S_DRIVE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRIVE: begin
                if (vec_q == MAX_IDX) begin
                    state_d = (SAMPLE_LAT == 0) ? S_EMIT : S_DRAIN;
                    drain_d = 2'd0;
                    ptr_d   = '0;
                end else begin
                    vec_d = vec_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_EMIT;
                    ptr_d   = '0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_EMIT: begin
                vec_d = '0;
                if (advance_s) begin
                    if (ptr_q == MAX_IDX) begin
                        state_d = S_DONE;
                        ptr_d   = '0;
                        count_d = popcount(sel_vec_s);
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end else begin
                    ptr_d = ptr_q;
                end
            end
            S_DONE: begin
                vec_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            table_q <= '0;
            count_q <= '0;
            ptr_q   <= '0;
            drain_q <= 2'd0;
`ifdef TTS_MAXTERM_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            table_q <= table_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            drain_q <= drain_d;
`ifdef TTS_MAXTERM_EN
            mode_q  <= mode_d;
`endif
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner (N_IN=4, SAMPLE_LAT=1).
module tb_truth_table_scanner;

    localparam int N     = 4;
    localparam int LAT   = 1;
    localparam int DEPTH = 16;
    localparam int ES    = 1 + DEPTH + LAT;   // first EMIT cycle after start cycle T

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             f_in = 1'b0;
    logic             minterm_ready = 1'b0;
    logic             mode_max = 1'b0;
    logic             busy, done, minterm_valid, minterm_last;
    logic [N-1:0]     vec, minterm_idx;
    logic [DEPTH-1:0] table_out;
    logic [N:0]       minterm_count;

    int checks = 0;
    int errors = 0;

    int               func_sel = 0;
    logic [DEPTH-1:0] rnd_tbl = '0;
    logic [N-1:0]     cur_vec = '0;

    int got_idx[$];
    bit got_last[$];
    int exp_list[$];

    truth_table_scanner #(.N_IN(N), .SAMPLE_LAT(LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .vec           (vec),
        .f_in          (f_in),
        .table_out     (table_out),
        .minterm_valid (minterm_valid),
        .minterm_ready (minterm_ready),
        .minterm_idx   (minterm_idx),
        .minterm_last  (minterm_last),
        .minterm_count (minterm_count)
`ifdef TTS_MAXTERM_EN
        ,
        .mode_max      (mode_max)
`endif
    );

    always #5 clk = ~clk;

    // Function under test as a boolean of the input combination.
    function automatic logic fmodel(input logic [N-1:0] v);
        case (func_sel)
            0:       return v[3] & v[0];
            1:       return 1'b0;
            2:       return 1'b1;
            default: return rnd_tbl[v];
        endcase
    endfunction

    // Function block with one cycle of response latency.
    always @(negedge clk) cur_vec = vec;
    always @(posedge clk) begin
        #1;
        f_in = fmodel(cur_vec);
    end

    // One full scan starting at cycle T; returns at the negedge of the done cycle.
    task automatic run_scan(input bit already, input int stall, input bit rnd_ready,
                            input int pulse_k, input bit mode, input string name);
        logic [DEPTH-1:0] exp_tbl;
        logic [N-1:0]     exp_v;
        int               exp_cnt, exp_done, k;
        bit               seen;
        exp_list.delete();
        got_idx.delete();
        got_last.delete();
        for (int i = 0; i < DEPTH; i++) exp_tbl[i] = fmodel(N'(i));
        for (int i = 0; i < DEPTH; i++) if ((exp_tbl[i] ^ mode) == 1'b1) exp_list.push_back(i);
        exp_cnt  = exp_list.size();
        exp_done = ES + DEPTH + ((stall > 0 && (exp_tbl[0] ^ mode) == 1'b1) ? stall : 0);
        mode_max = mode;
        if (!already) begin
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        k = 1;
        seen = 1'b0;
        while (!seen && k < 200) begin
            start = (k == pulse_k);
            if (rnd_ready) minterm_ready = 1'($urandom_range(0, 1));
            else           minterm_ready = !(k >= ES && k < ES + stall);
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL %s busy at k=%0d got %b want 1", name, k, busy);
            end
            if (k <= DEPTH + LAT) begin
                exp_v = (k <= DEPTH) ? N'(k - 1) : {N{1'b1}};
                checks++;
                if (vec !== exp_v) begin
                    errors++; $display("FAIL %s vec at k=%0d got %0d want %0d", name, k, vec, exp_v);
                end
            end
            if (k < ES) begin
                checks++;
                if (minterm_valid !== 1'b0) begin
                    errors++; $display("FAIL %s early valid at k=%0d got %b want 0", name, k, minterm_valid);
                end
            end
            if (!rnd_ready && k >= ES && k < ES + stall) begin
                checks++;
                if (minterm_valid !== 1'b1 || minterm_idx !== 4'd0) begin
                    errors++; $display("FAIL %s stall at k=%0d got valid %b idx %0d want 1/0", name, k, minterm_valid, minterm_idx);
                end
            end
            if (minterm_valid === 1'b1 && minterm_ready === 1'b1) begin
                got_idx.push_back(int'(minterm_idx));
                got_last.push_back(minterm_last);
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (table_out !== exp_tbl) begin
                    errors++; $display("FAIL %s table got %h want %h", name, table_out, exp_tbl);
                end
                checks++;
                if (int'(minterm_count) != exp_cnt) begin
                    errors++; $display("FAIL %s count got %0d want %0d", name, minterm_count, exp_cnt);
                end
                if (!rnd_ready) begin
                    checks++;
                    if (k != exp_done) begin
                        errors++; $display("FAIL %s done cycle got T+%0d want T+%0d", name, k, exp_done);
                    end
                end
            end
            if (!seen) begin
                @(posedge clk); #1;
                k++;
            end
        end
        start = 1'b0;
        if (!seen) begin
            errors++; $display("FAIL %s timeout got no done want done", name);
        end
        checks++;
        if (got_idx.size() != exp_list.size()) begin
            errors++; $display("FAIL %s emitted count got %0d want %0d", name, got_idx.size(), exp_list.size());
        end else begin
            for (int i = 0; i < got_idx.size(); i++) begin
                checks++;
                if (got_idx[i] != exp_list[i] || got_last[i] != (i == got_idx.size() - 1)) begin
                    errors++; $display("FAIL %s term %0d got idx %0d last %b want idx %0d last %b",
                                       name, i, got_idx[i], got_last[i], exp_list[i], (i == got_idx.size() - 1));
                end
            end
        end
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || vec !== 4'd0 || table_out !== 16'h0000 ||
            minterm_count !== 5'd0 || minterm_valid !== 1'b0 || minterm_idx !== 4'd0 || minterm_last !== 1'b0) begin
            errors++;
            $display("FAIL %s reset values got busy %b done %b vec %0d tbl %h cnt %0d val %b idx %0d last %b want all 0",
                     name, busy, done, vec, table_out, minterm_count, minterm_valid, minterm_idx, minterm_last);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_sop();
        int want[4] = '{9, 11, 13, 15};
        func_sel = 0;
        run_scan(1'b0, 0, 1'b0, 0, 1'b0, "sop");
        checks++;
        if (table_out !== 16'hAA00) begin
            errors++; $display("FAIL sop const table got %h want aa00", table_out);
        end
        checks++;
        if (got_idx.size() != 4) begin
            errors++; $display("FAIL sop const terms got %0d want 4", got_idx.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_idx[i] != want[i]) begin
                    errors++; $display("FAIL sop const term %0d got %0d want %0d", i, got_idx[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_zero();
        func_sel = 1;
        run_scan(1'b0, 0, 1'b0, 0, 1'b0, "zero");
    endtask

    task automatic test_ones_stall();
        func_sel = 2;
        run_scan(1'b0, 5, 1'b0, 0, 1'b0, "ones_stall");
        minterm_ready = 1'b1;
    endtask

    task automatic test_start_ignored();
        logic [DEPTH-1:0] saved;
        func_sel = 0;
        run_scan(1'b0, 0, 1'b0, ES + 3, 1'b0, "start_ignored");
        saved = 16'hAA00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || table_out !== saved) begin
                errors++; $display("FAIL start_ignored after done got done %b busy %b tbl %h want 0 0 %h",
                                   done, busy, table_out, saved);
            end
        end
    endtask

    task automatic test_back_to_back();
        func_sel = 3;
        rnd_tbl  = 16'($urandom);
        run_scan(1'b0, 0, 1'b0, 0, 1'b0, "b2b_first");
        start   = 1'b1;
        rnd_tbl = 16'($urandom);
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b idle gap got busy %b want 0", busy);
        end
        @(posedge clk); #1;
        run_scan(1'b1, 0, 1'b0, 0, 1'b0, "b2b_second");
    endtask

    task automatic test_random();
        func_sel = 3;
        for (int it = 0; it < 4; it++) begin
            rnd_tbl = 16'($urandom);
            run_scan(1'b0, 0, 1'b1, 0, 1'b0, "random");
        end
        minterm_ready = 1'b1;
    endtask

    task automatic test_abort();
        bit hit;
        func_sel = 2;
        hit = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (vec === 4'd7 && busy === 1'b1) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL abort vec7 got not reached want reached");
        end
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        @(posedge clk); #1 rst_n = 1'b1;
        func_sel = 3;
        rnd_tbl  = 16'($urandom);
        run_scan(1'b0, 0, 1'b0, 0, 1'b0, "after_abort");
    endtask

`ifdef TTS_MAXTERM_EN
    task automatic test_maxterm();
        func_sel = 0;
        run_scan(1'b0, 0, 1'b0, 0, 1'b1, "maxterm");
        mode_max = 1'b0;
    endtask
`endif

    initial begin
        minterm_ready = 1'b1;
        test_reset();
        test_sop();
        test_zero();
        test_ones_stall();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_abort();
`ifdef TTS_MAXTERM_EN
        test_maxterm();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
